// File: rtl/add_accum_stage.sv
// Accumulates N signed samples per result behind valid/ready handshakes.
// Define ADD_ACCUM_SAT_EN for clamping adds and the o_sat flag.
module add_accum_stage #(
   parameter int W     = 32,
   parameter int N     = 4,
   parameter int ACC_W = 40
) (
   input  logic                     i_clk,
   input  logic                     i_arst_n,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic signed [W-1:0]      i_a,
   input  logic                     i_clear,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic signed [ACC_W-1:0]  o_sum,
   output logic [$clog2(N+1)-1:0]   o_count
`ifdef ADD_ACCUM_SAT_EN
   ,
   output logic                     o_sat
`endif
);

   localparam int CW = $clog2(N+1);
   localparam logic [CW-1:0] LAST = CW'(N-1);

   typedef enum logic {IDLE, ACCUM} state_e;

   state_e                   state_q, state_d;
   logic signed [ACC_W-1:0]  acc_q, acc_d;
   logic signed [ACC_W-1:0]  sum_q, sum_d;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic                     valid_q, valid_d;

   logic signed [ACC_W-1:0]  base;
   logic signed [ACC_W-1:0]  ext_a;
   logic signed [ACC_W-1:0]  add_res;
   logic                     accept;
   logic                     take;

   assign o_ready = !valid_q || i_ready;
   assign accept  = i_valid && o_ready;
   assign take    = valid_q && i_ready;

   assign base  = (state_q == IDLE) ? '0 : acc_q;
   assign ext_a = ACC_W'($signed(i_a));

`ifdef ADD_ACCUM_SAT_EN
   localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

   logic [ACC_W:0] sum_x;
   logic           ovf;
   logic           psat_q, psat_d;
   logic           sat_q, sat_d;

   // One guard bit: the top two bits disagree exactly on signed overflow.
   assign sum_x   = {base[ACC_W-1], base} + {ext_a[ACC_W-1], ext_a};
   assign ovf     = sum_x[ACC_W] ^ sum_x[ACC_W-1];
   assign add_res = !ovf ? sum_x[ACC_W-1:0]
                  : (sum_x[ACC_W] ? SMIN : SMAX);
   assign o_sat   = sat_q;
`else
   assign add_res = base + ext_a;
`endif

   always_comb begin
      acc_d   = acc_q;
      sum_d   = sum_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
`ifdef ADD_ACCUM_SAT_EN
      psat_d  = psat_q;
      sat_d   = sat_q;
`endif
      if (i_clear) begin
         acc_d   = '0;
         cnt_d   = '0;
         valid_d = 1'b0;
`ifdef ADD_ACCUM_SAT_EN
         psat_d  = 1'b0;
         sat_d   = 1'b0;
`endif
      end else begin
         if (take) valid_d = 1'b0;
         if (accept) begin
            if (cnt_q == LAST) begin
               sum_d   = add_res;
               valid_d = 1'b1;
               acc_d   = '0;
               cnt_d   = '0;
`ifdef ADD_ACCUM_SAT_EN
               sat_d   = psat_q | ovf;
               psat_d  = 1'b0;
`endif
            end else begin
               acc_d = add_res;
               cnt_d = cnt_q + CW'(1);
`ifdef ADD_ACCUM_SAT_EN
               psat_d = psat_q | ovf;
`endif
            end
         end
      end
      state_d = (cnt_d == '0) ? IDLE : ACCUM;
   end

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         sum_q   <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
`ifdef ADD_ACCUM_SAT_EN
         psat_q  <= 1'b0;
         sat_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         sum_q   <= sum_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
`ifdef ADD_ACCUM_SAT_EN
         psat_q  <= psat_d;
         sat_q   <= sat_d;
`endif
      end
   end

   assign o_valid = valid_q;
   assign o_sum   = sum_q;
   assign o_count = cnt_q;

endmodule

// File: tb/tb_add_accum_stage.sv
// Randomized and directed checks of add_accum_stage against a
// queue-based reference model.
module tb_add_accum_stage;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_err = 0;

   // Instance A: defaults (W=32, N=4, ACC_W=40)
   logic               a_valid = 0, a_clear = 0, a_iready = 0;
   logic signed [31:0] a_in = 0;
   logic               a_ready, a_ovalid;
   logic signed [39:0] a_sum;
   logic [2:0]         a_count;
   // Instance B: N=1
   logic               b_valid = 0, b_clear = 0, b_iready = 0;
   logic signed [31:0] b_in = 0;
   logic               b_ready, b_ovalid;
   logic signed [39:0] b_sum;
   logic [0:0]         b_count;
   // Instance C: W=ACC_W=8, N=2
   logic               c_valid = 0, c_clear = 0, c_iready = 0;
   logic signed [7:0]  c_in = 0;
   logic               c_ready, c_ovalid;
   logic signed [7:0]  c_sum;
   logic [1:0]         c_count;
`ifdef ADD_ACCUM_SAT_EN
   logic a_sat, b_sat, c_sat;
`endif

   add_accum_stage u_a (
      .i_clk(clk), .i_arst_n(rst_n), .i_valid(a_valid), .o_ready(a_ready),
      .i_a(a_in), .i_clear(a_clear), .o_valid(a_ovalid), .i_ready(a_iready),
      .o_sum(a_sum), .o_count(a_count)
`ifdef ADD_ACCUM_SAT_EN
      , .o_sat(a_sat)
`endif
   );

   add_accum_stage #(.N(1)) u_b (
      .i_clk(clk), .i_arst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
      .i_a(b_in), .i_clear(b_clear), .o_valid(b_ovalid), .i_ready(b_iready),
      .o_sum(b_sum), .o_count(b_count)
`ifdef ADD_ACCUM_SAT_EN
      , .o_sat(b_sat)
`endif
   );

   add_accum_stage #(.W(8), .N(2), .ACC_W(8)) u_c (
      .i_clk(clk), .i_arst_n(rst_n), .i_valid(c_valid), .o_ready(c_ready),
      .i_a(c_in), .i_clear(c_clear), .o_valid(c_ovalid), .i_ready(c_iready),
      .o_sum(c_sum), .o_count(c_count)
`ifdef ADD_ACCUM_SAT_EN
      , .o_sat(c_sat)
`endif
   );

   // Reference model for instance A: pending samples plus output slot
   int               m_q[$];
   bit               m_valid;
   logic signed [39:0] m_sum;

   task automatic model_reset();
      m_q.delete();
      m_valid = 0;
      m_sum   = '0;
   endtask

   // One clock of instance A: check registered outputs, drive, update model
   task automatic cycle_a(input bit v, input int a, input bit rdy, input bit clr);
      bit exp_rdy;
      longint s;
      @(negedge clk);
      n_cmp++;
      if (a_ovalid !== m_valid) begin
         n_err++;
         $display("FAIL a_valid got=%0b exp=%0b t=%0t", a_ovalid, m_valid, $time);
      end
      n_cmp++;
      if (a_sum !== m_sum) begin
         n_err++;
         $display("FAIL a_sum got=%0d exp=%0d t=%0t", a_sum, m_sum, $time);
      end
      n_cmp++;
      if (a_count !== 3'(m_q.size())) begin
         n_err++;
         $display("FAIL a_count got=%0d exp=%0d t=%0t", a_count, m_q.size(), $time);
      end
`ifdef ADD_ACCUM_SAT_EN
      n_cmp++;
      if (a_sat !== 1'b0) begin
         n_err++;
         $display("FAIL a_sat got=%0b exp=0 t=%0t", a_sat, $time);
      end
`endif
      a_valid = v; a_in = a; a_iready = rdy; a_clear = clr;
      #1;
      exp_rdy = !m_valid || rdy;
      n_cmp++;
      if (a_ready !== exp_rdy) begin
         n_err++;
         $display("FAIL a_ready got=%0b exp=%0b t=%0t", a_ready, exp_rdy, $time);
      end
      if (clr) begin
         m_q.delete();
         m_valid = 0;
      end else begin
         if (m_valid && rdy) m_valid = 0;
         if (v && exp_rdy) begin
            m_q.push_back(a);
            if (m_q.size() == 4) begin
               s = 0;
               foreach (m_q[i]) s += longint'(m_q[i]);
               m_sum   = s[39:0];
               m_valid = 1;
               m_q.delete();
            end
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({a_ovalid, b_ovalid, c_ovalid} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_valid got=%b exp=000", {a_ovalid, b_ovalid, c_ovalid});
      end
      n_cmp++;
      if (a_sum !== 40'sd0 || b_sum !== 40'sd0 || c_sum !== 8'sd0) begin
         n_err++;
         $display("FAIL rst_sum got=%0d/%0d/%0d exp=0", a_sum, b_sum, c_sum);
      end
      n_cmp++;
      if (a_count !== 3'd0 || b_count !== 1'd0 || c_count !== 2'd0) begin
         n_err++;
         $display("FAIL rst_count got=%0d/%0d/%0d exp=0", a_count, b_count, c_count);
      end
      n_cmp++;
      if ({a_ready, b_ready, c_ready} !== 3'b111) begin
         n_err++;
         $display("FAIL rst_ready got=%b exp=111", {a_ready, b_ready, c_ready});
      end
`ifdef ADD_ACCUM_SAT_EN
      n_cmp++;
      if ({a_sat, b_sat, c_sat} !== 3'b000) begin
         n_err++;
         $display("FAIL rst_sat got=%b exp=000", {a_sat, b_sat, c_sat});
      end
`endif
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_basic();
      cycle_a(1, 1, 1, 0);
      cycle_a(1, 2, 1, 0);
      cycle_a(1, 3, 1, 0);
      cycle_a(1, 4, 1, 0);
      cycle_a(0, 0, 0, 0);
      n_cmp++;
      if (a_ovalid !== 1'b1 || a_sum !== 40'sd10) begin
         n_err++;
         $display("FAIL basic_sum got=%0b/%0d exp=1/10", a_ovalid, a_sum);
      end
      cycle_a(0, 0, 1, 0);
   endtask

   task automatic test_sign();
      cycle_a(1, -5, 1, 0);
      cycle_a(1, 7, 1, 0);
      cycle_a(1, -100, 1, 0);
      cycle_a(1, 3, 1, 0);
      cycle_a(0, 0, 0, 0);
      n_cmp++;
      if (a_sum !== -40'sd95) begin
         n_err++;
         $display("FAIL sign_sum got=%0d exp=-95", a_sum);
      end
      cycle_a(0, 0, 1, 0);
   endtask

   task automatic test_backpressure();
      for (int i = 0; i < 4; i++) cycle_a(1, 10 + i, 0, 0);
      for (int i = 0; i < 3; i++) cycle_a(1, int'($urandom), 0, 0);
      n_cmp++;
      if (a_ready !== 1'b0 || a_sum !== 40'sd46 || a_count !== 3'd0) begin
         n_err++;
         $display("FAIL bp_hold got=%0b/%0d/%0d exp=0/46/0", a_ready, a_sum, a_count);
      end
      cycle_a(0, 0, 1, 0);
      cycle_a(0, 0, 1, 0);
   endtask

   task automatic test_clear();
      cycle_a(1, 9, 1, 0);
      cycle_a(1, 9, 1, 0);
      cycle_a(1, 9, 1, 1);
      for (int i = 0; i < 4; i++) cycle_a(1, 1, 1, 0);
      cycle_a(0, 0, 0, 0);
      n_cmp++;
      if (a_sum !== 40'sd4) begin
         n_err++;
         $display("FAIL clear_sum got=%0d exp=4", a_sum);
      end
      cycle_a(0, 0, 1, 0);
   endtask

   task automatic test_reset_mid();
      cycle_a(1, 50, 1, 0);
      cycle_a(1, 60, 1, 0);
      @(negedge clk);
      a_valid = 0;
      #2 rst_n = 0;
      #1;
      n_cmp++;
      if (a_ovalid !== 1'b0 || a_sum !== 40'sd0 || a_count !== 3'd0) begin
         n_err++;
         $display("FAIL rst_mid got=%0b/%0d/%0d exp=0/0/0", a_ovalid, a_sum, a_count);
      end
      @(negedge clk);
      rst_n = 1;
      model_reset();
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++)
         cycle_a(($urandom % 4) != 0, int'($urandom), ($urandom % 3) != 0,
                 ($urandom % 40) == 0);
      cycle_a(0, 0, 1, 0);
      cycle_a(0, 0, 1, 0);
   endtask

   task automatic test_back_to_back();
      for (int i = 1; i <= 9; i++) begin
         @(negedge clk);
         if (i > 1) begin
            n_cmp++;
            if (b_ovalid !== 1'b1 || b_sum !== 40'(i - 1) || b_ready !== 1'b1) begin
               n_err++;
               $display("FAIL b2b_%0d got=%0b/%0d/%0b exp=1/%0d/1",
                        i - 1, b_ovalid, b_sum, b_ready, i - 1);
            end
         end
         b_iready = 1;
         b_valid  = (i <= 8);
         b_in     = i;
      end
      @(negedge clk);
      n_cmp++;
      if (b_ovalid !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_drain got=%0b exp=0", b_ovalid);
      end
   endtask

   task automatic test_overflow();
      @(negedge clk);
      c_iready = 1; c_valid = 1; c_in = 8'sd127;
      @(negedge clk);
      c_in = 8'sd1;
      @(negedge clk);
      c_valid = 0;
      n_cmp++;
`ifdef ADD_ACCUM_SAT_EN
      if (c_ovalid !== 1'b1 || c_sum !== 8'sd127 || c_sat !== 1'b1) begin
         n_err++;
         $display("FAIL ovf got=%0b/%0d/%0b exp=1/127/1", c_ovalid, c_sum, c_sat);
      end
`else
      if (c_ovalid !== 1'b1 || c_sum !== -8'sd128) begin
         n_err++;
         $display("FAIL ovf got=%0b/%0d exp=1/-128", c_ovalid, c_sum);
      end
`endif
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_sign();
      test_backpressure();
      test_clear();
      test_reset_mid();
      test_random();
      test_back_to_back();
      test_overflow();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
